// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store Funct3 encodings, the LSU state type and
// the alignment rule used by the memory stage.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  // Unsupported encodings count as misaligned; stores have no unsigned forms.
  function automatic logic is_misaligned(input logic is_store, input logic [2:0] f3,
                                         input logic [1:0] a);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = a[0];
      F3_W:    bad = (a != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends
// it according to the load Funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_W:    result = rdata;
      F3_BU:   result = {24'h0, byte_lane};
      F3_HU:   result = {16'h0, half_lane};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues the EX/MEM access to data memory, stalls the
// pipeline until ack or timeout, and gates RegWrite on misalign/timeout faults.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        RegWriteM,
  output logic        RegWriteGatedM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        FaultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  // Handshake: dmem_req is held high until the cycle dmem_ack is seen with it;
  // that cycle completes the access. Address/data are stable while StallM holds
  // the EX/MEM register frozen.
  lsu_state_t    state;
  logic [CW-1:0] cnt;

  logic        access, misal, legal, timeout_hit, done;
  logic [3:0]  be_raw;
  logic [31:0] wd_raw, ext_data;

  assign access      = MemReadM | MemWriteM;
  assign misal       = access & is_misaligned(MemWriteM, Funct3M, ALUResultM[1:0]);
  assign legal       = access & ~misal;
  assign timeout_hit = (state == WAIT) && (cnt == CNT_MAX);

  assign dmem_req = ~reset & (((state == IDLE) & legal) | ((state == WAIT) & ~timeout_hit));
  assign done     = dmem_req & dmem_ack;

  assign StallM    = dmem_req & ~dmem_ack;
  assign MisalignM = ~reset & (state == IDLE) & misal;
  assign FaultM    = ~reset & timeout_hit;

  // Writeback is allowed only for non-memory instructions or a completed access.
  assign RegWriteGatedM = ~reset & RegWriteM & (done | ((state == IDLE) & ~access));

  always_comb begin
    case (Funct3M[1:0])
      2'b00: begin
        be_raw = 4'b0001 << ALUResultM[1:0];
        wd_raw = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_raw = 4'b0011 << ALUResultM[1:0];
        wd_raw = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_raw = 4'b1111;
        wd_raw = WriteDataM;
      end
    endcase
  end

  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = dmem_req ? {ALUResultM[31:2], 2'b00} : 32'h0;
  assign dmem_be    = dmem_req ? be_raw : 4'b0000;
  assign dmem_wdata = dmem_req ? wd_raw : 32'h0;

  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .addr   (ALUResultM[1:0]),
    .funct3 (Funct3M),
    .result (ext_data)
  );

  assign ReadDataM = (done & MemReadM) ? ext_data : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (legal && !dmem_ack) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (timeout_hit || dmem_ack) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed-vector bench for lsu_mem_stage: a driver issues accesses and pushes
// the hand-computed response; a monitor pops and compares at each completion.
module tb_lsu_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk, reset;
  logic        MemReadM, MemWriteM, RegWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        RegWriteGatedM, StallM, MisalignM, FaultM;
  logic [31:0] ReadDataM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] rd;
    logic        rw;
    logic        mis;
    logic        flt;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  n_stall;
    logic [7:0]  n_req;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ns = 0;
  int   nr = 0;

  lsu_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemReadM       (MemReadM),
    .MemWriteM      (MemWriteM),
    .Funct3M        (Funct3M),
    .ALUResultM     (ALUResultM),
    .WriteDataM     (WriteDataM),
    .RegWriteM      (RegWriteM),
    .RegWriteGatedM (RegWriteGatedM),
    .ReadDataM      (ReadDataM),
    .StallM         (StallM),
    .MisalignM      (MisalignM),
    .FaultM         (FaultM),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] id, input logic [31:0] rd, input logic rw,
                              input logic mis, input logic flt, input logic we,
                              input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input int n_stall, input int n_req);
    exp_t e;
    e.id = id; e.rd = rd; e.rw = rw; e.mis = mis; e.flt = flt; e.we = we;
    e.addr = addr; e.be = be; e.wdata = wdata;
    e.n_stall = 8'(n_stall); e.n_req = 8'(n_req);
    return e;
  endfunction

  task automatic idle();
    MemReadM = 1'b0; MemWriteM = 1'b0; RegWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
  endtask

  // ack_at: cycle index (0 = IDLE cycle) on which ack is driven; -1 = never.
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic rw, input logic [31:0] rdata,
                        input int ack_at, input exp_t e);
    int cycles;
    exp_q.push_back(e);
    MemReadM = ~wr; MemWriteM = wr; Funct3M = f3; ALUResultM = a;
    WriteDataM = wd; RegWriteM = rw; dmem_rdata = rdata;
    cycles = e.mis ? 1 : (ack_at >= 0 ? ack_at + 1 : TIMEOUT + 2);
    for (int c = 0; c < cycles; c++) begin
      dmem_ack = (c == ack_at);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      ns = 0; nr = 0;
    end else begin
      ns += int'(StallM);
      nr += int'(dmem_req);
      if ((dmem_req && dmem_ack) || MisalignM || FaultM) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_event: got req=%b ack=%b mis=%b flt=%b expected none",
                   dmem_req, dmem_ack, MisalignM, FaultM);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d ReadDataM", e.id), ReadDataM, e.rd);
          chk($sformatf("v%0d RegWriteGatedM", e.id), 32'(RegWriteGatedM), 32'(e.rw));
          chk($sformatf("v%0d MisalignM", e.id), 32'(MisalignM), 32'(e.mis));
          chk($sformatf("v%0d FaultM", e.id), 32'(FaultM), 32'(e.flt));
          chk($sformatf("v%0d dmem_we", e.id), 32'(dmem_we), 32'(e.we));
          chk($sformatf("v%0d dmem_addr", e.id), dmem_addr, e.addr);
          chk($sformatf("v%0d dmem_be", e.id), 32'(dmem_be), 32'(e.be));
          chk($sformatf("v%0d dmem_wdata", e.id), dmem_wdata, e.wdata);
          chk($sformatf("v%0d stall_cycles", e.id), 32'(ns), 32'(e.n_stall));
          chk($sformatf("v%0d req_cycles", e.id), 32'(nr), 32'(e.n_req));
        end
        ns = 0; nr = 0;
      end
    end
  end

  initial begin
    int guard;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("reset dmem_req", 32'(dmem_req), 32'h0);
    chk("reset StallM", 32'(StallM), 32'h0);
    chk("reset ReadDataM", ReadDataM, 32'h0);
    chk("reset outputs", {dmem_be, dmem_we, MisalignM, FaultM, RegWriteGatedM}, 32'h0);
    chk("reset dmem_addr", dmem_addr, 32'h0);

    // ack with no request is ignored; RegWrite passes through for non-memory ops
    @(posedge clk); #1;
    dmem_ack = 1'b1; RegWriteM = 1'b1;
    @(negedge clk);
    chk("stray_ack dmem_req", 32'(dmem_req), 32'h0);
    chk("stray_ack StallM", 32'(StallM), 32'h0);
    chk("stray_ack ReadDataM", ReadDataM, 32'h0);
    chk("nomem RegWriteGatedM", 32'(RegWriteGatedM), 32'h1);
    @(posedge clk); #1;
    idle();

    // back-to-back directed vectors
    access(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 0,
           mk(1, 32'hDEADBEEF, 1, 0, 0, 0, 32'h100, 4'hF, 32'h0, 0, 1));
    access(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 32'h80FFFF7F, 3,
           mk(2, 32'hFFFFFF80, 1, 0, 0, 0, 32'h100, 4'h8, 32'h0, 3, 4));
    access(1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 32'hABCD1234, 1,
           mk(3, 32'h0000ABCD, 1, 0, 0, 0, 32'h100, 4'hC, 32'h0, 1, 2));
    access(1'b1, 3'b001, 32'h102, 32'h5A5A1234, 1'b0, 32'h0, 0,
           mk(4, 32'h0, 0, 0, 0, 1, 32'h100, 4'hC, 32'h12341234, 0, 1));
    access(1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0, -1,
           mk(5, 32'h0, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0));
    access(1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 32'h80017FFF, 2,
           mk(6, 32'hFFFF8001, 1, 0, 0, 0, 32'h100, 4'hC, 32'h0, 2, 3));
    access(1'b0, 3'b100, 32'h101, 32'h0, 1'b1, 32'h0000C300, 0,
           mk(7, 32'h000000C3, 1, 0, 0, 0, 32'h100, 4'h2, 32'h0, 0, 1));
    access(1'b1, 3'b000, 32'h203, 32'h123456A5, 1'b0, 32'h0, TIMEOUT,
           mk(8, 32'h0, 0, 0, 0, 1, 32'h200, 4'h8, 32'hA5A5A5A5, TIMEOUT, TIMEOUT + 1));
    access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 1'b0, 32'h0, 0,
           mk(9, 32'h0, 0, 0, 0, 1, 32'h300, 4'hF, 32'hCAFEF00D, 0, 1));
    access(1'b1, 3'b100, 32'h300, 32'h11, 1'b0, 32'h0, -1,
           mk(10, 32'h0, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0));
    access(1'b0, 3'b011, 32'h200, 32'h0, 1'b1, 32'h0, -1,
           mk(11, 32'h0, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0));
    access(1'b0, 3'b010, 32'h104, 32'h0, 1'b1, 32'h12345678, -1,
           mk(12, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, TIMEOUT + 1, TIMEOUT + 1));
    // ack arriving in the timeout cycle is ignored
    access(1'b0, 3'b010, 32'h010, 32'h0, 1'b1, 32'h55AA55AA, TIMEOUT + 1,
           mk(13, 32'h0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, TIMEOUT + 1, TIMEOUT + 1));
    idle();
    @(posedge clk); #1;

    // reset in the 2nd WAIT cycle aborts the access silently
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h108; RegWriteM = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort WAIT1 StallM", 32'(StallM), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort reset FaultM", 32'(FaultM), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("abort after dmem_req", 32'(dmem_req), 32'h0);
    chk("abort after StallM", 32'(StallM), 32'h0);
    chk("abort after FaultM", 32'(FaultM), 32'h0);
    chk("abort after MisalignM", 32'(MisalignM), 32'h0);
    @(posedge clk); #1;
    access(1'b1, 3'b010, 32'h10C, 32'h11223344, 1'b0, 32'h0, 0,
           mk(14, 32'h0, 0, 0, 0, 1, 32'h10C, 4'hF, 32'h11223344, 0, 1));
    idle();

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
